vga_sync_decoder: RTL and testbench

- Receive-side counterpart of the 640x480 VGA timing generator. Consumes hsync/vsync/valid from any same-clock source, such as a generator output looped back, a scaler or an overlay stage.
- Measures line length and frame height, and declares lock after consecutive conforming frames.
- Recovers registered pixel coordinates for downstream pixel logic such as sprite compare and collision checks.

---
 rtl/vga_pkg.sv | 22 ++
 rtl/vga_edge_det.sv | 25 ++
 rtl/vga_sync_decoder.sv | 210 +++++++++++++++++++++
 tb/tb_vga_sync_decoder.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared 640x480 VGA timing constants and the lock FSM state encoding
// used by the receive-side sync decoder.
package vga_pkg;

   localparam int unsigned VGA_H_TOTAL     = 800;
   localparam int unsigned VGA_V_TOTAL     = 525;
   localparam int unsigned VGA_H_SYNC      = 96;
   localparam int unsigned VGA_V_SYNC      = 2;
   localparam int unsigned VGA_H_ACT_START = 144;
   localparam int unsigned VGA_V_ACT_START = 35;
   localparam int unsigned VGA_LOCK_FRAMES = 2;
   localparam int unsigned VGA_CNT_W       = 10;
   localparam int unsigned VGA_GOOD_W      = 4;
   localparam int unsigned VGA_ERR_W       = 8;

   typedef enum logic [1:0] {
      ST_UNLOCKED  = 2'd0,
      ST_MEASURING = 2'd1,
      ST_LOCKED    = 2'd2
   } lock_state_e;

endpackage

// File: rtl/vga_edge_det.sv
// Registered edge detector: holds the previous input level and flags
// rising/falling transitions combinationally against the live input.
module vga_edge_det #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q,
   output logic rise_c,
   output logic fall_c
);

   logic d_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) d_q <= RST_VAL;
      else        d_q <= d;
   end

   assign q      = d_q;
   assign rise_c = ~d_q & d;
   assign fall_c = d_q & ~d;

endmodule

// File: rtl/vga_sync_decoder.sv
// VGA sync decoder: measures line/frame timing, declares lock and recovers
// pixel coordinates. Define VGA_DECODER_ERR_CNT_EN to build the error counter.
module vga_sync_decoder
   import vga_pkg::*;
#(
   parameter int unsigned H_TOTAL     = VGA_H_TOTAL,
   parameter int unsigned V_TOTAL     = VGA_V_TOTAL,
   parameter int unsigned LOCK_FRAMES = VGA_LOCK_FRAMES,
   parameter int unsigned CNT_W       = VGA_CNT_W
) (
   input  logic             pclk,
   input  logic             reset,
   input  logic             hsync,
   input  logic             vsync,
   input  logic             de,
   output logic [CNT_W-1:0] x,
   output logic [CNT_W-1:0] y,
   output logic             pix_valid,
   output logic             sof,
   output logic [CNT_W-1:0] line_len,
   output logic [CNT_W-1:0] frame_lines,
   output logic             locked,
   output logic [7:0]       err_cnt
);

   localparam logic [CNT_W-1:0]      H_TOT_C = CNT_W'(H_TOTAL);
   localparam logic [CNT_W-1:0]      V_TOT_C = CNT_W'(V_TOTAL);
   localparam logic [CNT_W-1:0]      CNT_MAX = {CNT_W{1'b1}};
   localparam logic [VGA_GOOD_W-1:0] LOCK_C  = VGA_GOOD_W'(LOCK_FRAMES);

   logic hs_q, vs_q, de_q;
   logic hs_rise_c, hs_fall_c, vs_rise_c, vs_fall_c, de_rise_c, de_fall_c;
   logic unused_edges;

   logic [CNT_W-1:0] h_meas_q, h_meas_d, v_meas_q, v_meas_d;
   logic [CNT_W-1:0] line_len_q, line_len_d, frame_lines_q, frame_lines_d;
   logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
   logic             line_bad_q, line_bad_d, hs_seen_q, hs_seen_d;
   logic             locked_q, locked_d, pix_valid_q, pix_valid_d, sof_q, sof_d;
   logic [VGA_GOOD_W-1:0] good_cnt_q, good_cnt_d;
   lock_state_e      state_q, state_d;

   logic h_sat_c, hs_bad_c, vs_bad_c, frame_good_c;

   vga_edge_det #(.RST_VAL(1'b1)) u_hs_det (
      .clk(pclk), .rst_n(reset), .d(hsync), .q(hs_q), .rise_c(hs_rise_c), .fall_c(hs_fall_c)
   );
   vga_edge_det #(.RST_VAL(1'b1)) u_vs_det (
      .clk(pclk), .rst_n(reset), .d(vsync), .q(vs_q), .rise_c(vs_rise_c), .fall_c(vs_fall_c)
   );
   vga_edge_det #(.RST_VAL(1'b0)) u_de_det (
      .clk(pclk), .rst_n(reset), .d(de), .q(de_q), .rise_c(de_rise_c), .fall_c(de_fall_c)
   );

   assign unused_edges = ^{hs_q, vs_q, hs_rise_c, vs_rise_c};

   // Timing qualifiers; a pinned h_meas only counts as lost sync when no hs_fall restarts it.
   always_comb begin
      h_sat_c      = (h_meas_q == CNT_MAX) && !hs_fall_c;
      hs_bad_c     = hs_fall_c && hs_seen_q && (h_meas_q != H_TOT_C);
      vs_bad_c     = vs_fall_c && (v_meas_q != V_TOT_C);
      frame_good_c = (v_meas_q == V_TOT_C) && !line_bad_q && !hs_bad_c;
   end

   // Line and frame measurement; a line that coincides with vs_fall opens the new frame.
   always_comb begin
      h_meas_d      = h_meas_q;
      v_meas_d      = v_meas_q;
      line_len_d    = line_len_q;
      frame_lines_d = frame_lines_q;
      line_bad_d    = line_bad_q;
      hs_seen_d     = hs_seen_q;

      if (hs_fall_c) begin
         line_len_d = h_meas_q;
         h_meas_d   = CNT_W'(1);
         hs_seen_d  = 1'b1;
      end else if (h_meas_q != CNT_MAX) begin
         h_meas_d = h_meas_q + CNT_W'(1);
      end

      if (vs_fall_c) begin
         frame_lines_d = v_meas_q;
         v_meas_d      = hs_fall_c ? CNT_W'(1) : '0;
      end else if (hs_fall_c && (v_meas_q != CNT_MAX)) begin
         v_meas_d = v_meas_q + CNT_W'(1);
      end

      if (vs_fall_c)     line_bad_d = 1'b0;
      else if (hs_bad_c) line_bad_d = 1'b1;
   end

   // Lock FSM next state.
   always_comb begin
      state_d    = state_q;
      good_cnt_d = good_cnt_q;

      if (h_sat_c) begin
         state_d    = ST_UNLOCKED;
         good_cnt_d = '0;
      end else begin
         case (state_q)
            ST_UNLOCKED: begin
               if (vs_fall_c) begin
                  state_d    = ST_MEASURING;
                  good_cnt_d = '0;
               end
            end
            ST_MEASURING: begin
               if (vs_fall_c) begin
                  if (frame_good_c) begin
                     good_cnt_d = good_cnt_q + VGA_GOOD_W'(1);
                     if ((good_cnt_q + VGA_GOOD_W'(1)) >= LOCK_C) state_d = ST_LOCKED;
                  end else begin
                     good_cnt_d = '0;
                  end
               end
            end
            ST_LOCKED: begin
               if (hs_bad_c || vs_bad_c || (v_meas_q > V_TOT_C)) begin
                  state_d    = ST_MEASURING;
                  good_cnt_d = '0;
               end
            end
            default: begin
               state_d    = ST_UNLOCKED;
               good_cnt_d = '0;
            end
         endcase
      end

      locked_d = (state_d == ST_LOCKED);
   end

   // Pixel coordinates, qualified output and start-of-frame pulse.
   always_comb begin
      x_d = x_q;
      y_d = y_q;

      if (de_rise_c)                  x_d = '0;
      else if (de_q && x_q != CNT_MAX) x_d = x_q + CNT_W'(1);

      if (vs_fall_c)                       y_d = '0;
      else if (de_fall_c && y_q != CNT_MAX) y_d = y_q + CNT_W'(1);

      pix_valid_d = de && locked_q;
      sof_d       = vs_fall_c;
   end

   always_ff @(posedge pclk or negedge reset) begin
      if (!reset) begin
         h_meas_q      <= '0;
         v_meas_q      <= '0;
         line_len_q    <= '0;
         frame_lines_q <= '0;
         line_bad_q    <= 1'b0;
         hs_seen_q     <= 1'b0;
         state_q       <= ST_UNLOCKED;
         good_cnt_q    <= '0;
         locked_q      <= 1'b0;
         x_q           <= '0;
         y_q           <= '0;
         pix_valid_q   <= 1'b0;
         sof_q         <= 1'b0;
      end else begin
         h_meas_q      <= h_meas_d;
         v_meas_q      <= v_meas_d;
         line_len_q    <= line_len_d;
         frame_lines_q <= frame_lines_d;
         line_bad_q    <= line_bad_d;
         hs_seen_q     <= hs_seen_d;
         state_q       <= state_d;
         good_cnt_q    <= good_cnt_d;
         locked_q      <= locked_d;
         x_q           <= x_d;
         y_q           <= y_d;
         pix_valid_q   <= pix_valid_d;
         sof_q         <= sof_d;
      end
   end

`ifdef VGA_DECODER_ERR_CNT_EN
   logic [VGA_ERR_W-1:0] err_cnt_q, err_cnt_d;

   // Saturating count of bad edges seen once measurement has started.
   always_comb begin
      err_cnt_d = err_cnt_q;
      if ((state_q != ST_UNLOCKED) && (hs_bad_c || vs_bad_c) && (err_cnt_q != {VGA_ERR_W{1'b1}}))
         err_cnt_d = err_cnt_q + VGA_ERR_W'(1);
   end

   always_ff @(posedge pclk or negedge reset) begin
      if (!reset) err_cnt_q <= '0;
      else        err_cnt_q <= err_cnt_d;
   end

   assign err_cnt = err_cnt_q;
`else
   assign err_cnt = 8'd0;
`endif

   assign x           = x_q;
   assign y           = y_q;
   assign pix_valid   = pix_valid_q;
   assign sof         = sof_q;
   assign line_len    = line_len_q;
   assign frame_lines = frame_lines_q;
   assign locked      = locked_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder: scaled-down raster (40x20 total, 24x12 active)
// so lock, loss and relock scenarios fit in a short run.
module tb_vga_sync_decoder;

   localparam int H_T = 40, V_T = 20, LF = 2, CW = 10, CMAX = 1023;
   localparam int H_SYNC = 4, H_ACT0 = 8, H_ACT = 24;
   localparam int V_SYNC = 2, V_ACT0 = 4, V_ACT = 12;
`ifdef VGA_DECODER_ERR_CNT_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif
   localparam int MU = 0, MM = 1, ML = 2;

   logic pclk = 1'b0, reset = 1'b0, hsync = 1'b1, vsync = 1'b1, de = 1'b0;
   logic [CW-1:0] x, y, line_len, frame_lines;
   logic pix_valid, sof, locked;
   logic [7:0] err_cnt;

   vga_sync_decoder #(.H_TOTAL(H_T), .V_TOTAL(V_T), .LOCK_FRAMES(LF), .CNT_W(CW)) dut (
      .pclk(pclk), .reset(reset), .hsync(hsync), .vsync(vsync), .de(de),
      .x(x), .y(y), .pix_valid(pix_valid), .sof(sof), .line_len(line_len),
      .frame_lines(frame_lines), .locked(locked), .err_cnt(err_cnt)
   );

   always #5 pclk = ~pclk;

   int n_chk = 0, n_pass = 0;
   int pv_cnt, sof_cnt, first_x, first_y, last_x, last_y;
   bit pv_seen, first_lk;

   // Reference model state: elapsed cycles/lines as plain integers.
   bit m_phs, m_pvs, m_pde, m_seen, m_bad, m_pv, m_sof, m_lk;
   int m_since, m_lines, m_mode, m_good, m_x, m_y, m_ll, m_fl, m_err;

   typedef struct {
      logic hs, vs, d;
      logic e_sof;
      int   e_ll, e_fl, e_x, e_y;
   } vec_t;

   function automatic int sat(input int n);
      return (n > CMAX) ? CMAX : n;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic model_reset();
      m_phs = 1; m_pvs = 1; m_pde = 0; m_seen = 0; m_bad = 0;
      m_since = 0; m_lines = 0; m_mode = MU; m_good = 0;
      m_x = 0; m_y = 0; m_pv = 0; m_sof = 0; m_ll = 0; m_fl = 0; m_lk = 0; m_err = 0;
   endtask

   task automatic model_step(input bit hs, input bit vs, input bit d);
      bit hf, vf, dr, df, lbad, vbad, stuck, ok, old_lk;
      int hm, vm, old_mode;
      hf = m_phs && !hs;  vf = m_pvs && !vs;
      dr = !m_pde && d;   df = m_pde && !d;
      hm = sat(m_since);  vm = sat(m_lines);
      lbad  = hf && m_seen && (hm != H_T);
      vbad  = vf && (vm != V_T);
      stuck = (hm == CMAX) && !hf;
      ok    = (vm == V_T) && !m_bad && !lbad;
      old_mode = m_mode; old_lk = m_lk;
      if (stuck) begin
         m_mode = MU; m_good = 0;
      end else if (m_mode == MU) begin
         if (vf) begin m_mode = MM; m_good = 0; end
      end else if (m_mode == MM) begin
         if (vf) begin
            if (ok) begin m_good++; if (m_good >= LF) m_mode = ML; end
            else m_good = 0;
         end
      end else if (lbad || vbad || vm > V_T) begin
         m_mode = MM; m_good = 0;
      end
      if (ERR_EN && old_mode != MU && (lbad || vbad) && m_err < 255) m_err++;
      m_lk  = (m_mode == ML);
      m_pv  = d && old_lk;
      m_sof = vf;
      if (dr) m_x = 0; else if (m_pde) m_x = sat(m_x + 1);
      if (vf) m_y = 0; else if (df) m_y = sat(m_y + 1);
      if (hf) begin m_ll = hm; m_seen = 1; end
      if (vf) m_fl = vm;
      if (vf) m_bad = 0; else if (lbad) m_bad = 1;
      if (vf) m_lines = hf ? 1 : 0; else if (hf) m_lines = sat(m_lines + 1);
      m_since = hf ? 1 : sat(m_since + 1);
      m_phs = hs; m_pvs = vs; m_pde = d;
   endtask

   task automatic cmp_model();
      bit ok;
      ok = (int'(x) == m_x) && (int'(y) == m_y) && (pix_valid == m_pv) && (sof == m_sof) &&
           (int'(line_len) == m_ll) && (int'(frame_lines) == m_fl) && (locked == m_lk) &&
           (int'(err_cnt) == m_err);
      n_chk++;
      if (ok) n_pass++;
      else $display("FAIL model @%0t got/exp: x=%0d/%0d y=%0d/%0d pv=%0d/%0d sof=%0d/%0d ll=%0d/%0d fl=%0d/%0d lk=%0d/%0d err=%0d/%0d",
                    $time, x, m_x, y, m_y, pix_valid, m_pv, sof, m_sof, line_len, m_ll,
                    frame_lines, m_fl, locked, m_lk, err_cnt, m_err);
   endtask

   // One pclk: drive at negedge, model at posedge, compare at next negedge.
   task automatic cycle(input bit h, input bit v, input bit d);
      hsync = h; vsync = v; de = d;
      @(posedge pclk);
      model_step(h, v, d);
      @(negedge pclk);
      cmp_model();
      if (pix_valid) begin
         pv_cnt++;
         if (!pv_seen) begin first_x = int'(x); first_y = int'(y); pv_seen = 1; end
         last_x = int'(x); last_y = int'(y);
      end
      if (sof) sof_cnt++;
   endtask

   task automatic gen_frame(input int lines, input int long_line, input int extra);
      pv_cnt = 0; pv_seen = 0; sof_cnt = 0;
      for (int v = 0; v < lines; v++) begin
         int len;
         len = H_T + ((v == long_line) ? extra : 0);
         for (int h = 0; h < len; h++) begin
            cycle(h >= H_SYNC, v >= V_SYNC,
                  (h >= H_ACT0) && (h < H_ACT0 + H_ACT) && (v >= V_ACT0) && (v < V_ACT0 + V_ACT));
            if (v == 0 && h == 0) first_lk = locked;
         end
      end
   endtask

   task automatic check_locked_frame(input string tag);
      check({tag, "_locked"}, int'(locked), 1);
      check({tag, "_pv_cnt"}, pv_cnt, H_ACT * V_ACT);
      check({tag, "_first_x"}, first_x, 0);
      check({tag, "_first_y"}, first_y, 0);
      check({tag, "_last_x"}, last_x, H_ACT - 1);
      check({tag, "_last_y"}, last_y, V_ACT - 1);
      check({tag, "_line_len"}, int'(line_len), H_T);
      check({tag, "_frame_lines"}, int'(frame_lines), V_T);
      check({tag, "_sof_cnt"}, sof_cnt, 1);
   endtask

   task automatic do_reset();
      reset = 1'b0; hsync = 1'b1; vsync = 1'b1; de = 1'b0;
      model_reset();
      repeat (3) @(negedge pclk);
      reset = 1'b1;
   endtask

   initial begin
      vec_t tbl[8];
      tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0};
      tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 1, 0, 0, 0};
      tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1, 0, 0, 0};
      tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 2, 0, 0, 0};
      tbl[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 2, 2, 0, 0};
      tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 2, 2, 1, 0};
      tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 2, 2, 2, 1};
      tbl[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 2, 2, 2, 1};

      do_reset();
      check("reset_locked", int'(locked), 0);
      check("reset_sof", int'(sof), 0);
      check("reset_line_len", int'(line_len), 0);
      check("reset_err", int'(err_cnt), 0);

      // Short hand-built vectors exercising the measurement edges directly.
      for (int i = 0; i < 8; i++) begin
         cycle(tbl[i].hs, tbl[i].vs, tbl[i].d);
         check($sformatf("vec%0d_sof", i), int'(sof), int'(tbl[i].e_sof));
         check($sformatf("vec%0d_line_len", i), int'(line_len), tbl[i].e_ll);
         check($sformatf("vec%0d_frame_lines", i), int'(frame_lines), tbl[i].e_fl);
         check($sformatf("vec%0d_x", i), int'(x), tbl[i].e_x);
         check($sformatf("vec%0d_y", i), int'(y), tbl[i].e_y);
      end

      // Clean lock-up from reset.
      do_reset();
      gen_frame(V_T, -1, 0);
      gen_frame(V_T, -1, 0);
      check("lock_early", int'(locked), 0);
      gen_frame(V_T, -1, 0);
      check("lock_rise", int'(first_lk), 1);
      check_locked_frame("f2");
      gen_frame(V_T, -1, 0);
      check_locked_frame("f3");

      // One line one cycle long drops lock; two clean frames relock.
      gen_frame(V_T, 5, 1);
      check("long_unlocked", int'(locked), 0);
      check("long_line_len", int'(line_len), H_T);
      check("long_err", int'(err_cnt), ERR_EN ? 1 : 0);
      gen_frame(V_T, -1, 0);
      gen_frame(V_T, -1, 0);
      check("long_relock_early", int'(locked), 0);
      gen_frame(V_T, -1, 0);
      check("long_relock_rise", int'(first_lk), 1);
      check_locked_frame("f7");
      check("long_err_hold", int'(err_cnt), ERR_EN ? 1 : 0);

      // hsync stuck high: h_meas saturates and sync is lost.
      pv_cnt = 0;
      repeat (1100) cycle(1'b1, 1'b1, 1'b0);
      check("stuck_unlocked", int'(locked), 0);
      check("stuck_pv", pv_cnt, 0);
      gen_frame(V_T, -1, 0);
      gen_frame(V_T, -1, 0);
      check("stuck_relock_early", int'(locked), 0);
      gen_frame(V_T, -1, 0);
      check("stuck_relock_rise", int'(first_lk), 1);

      // Asynchronous reset in the middle of a locked line.
      gen_frame(3, -1, 0);
      for (int h = 0; h < 10; h++) cycle(h >= H_SYNC, 1'b1, 1'b0);
      check("pre_rst_locked", int'(locked), 1);
      #2 reset = 1'b0;
      #1;
      check("arst_x", int'(x), 0);
      check("arst_y", int'(y), 0);
      check("arst_pv", int'(pix_valid), 0);
      check("arst_sof", int'(sof), 0);
      check("arst_line_len", int'(line_len), 0);
      check("arst_frame_lines", int'(frame_lines), 0);
      check("arst_locked", int'(locked), 0);
      check("arst_err", int'(err_cnt), 0);
      model_reset();
      repeat (2) @(negedge pclk);
      reset = 1'b1;
      sof_cnt = 0;
      repeat (50) cycle(1'b1, 1'b1, 1'b0);
      check("post_rst_no_sof", sof_cnt, 0);
      gen_frame(V_T, -1, 0);
      gen_frame(V_T, -1, 0);
      check("rst_relock_early", int'(locked), 0);
      gen_frame(V_T, -1, 0);
      check("rst_relock_rise", int'(first_lk), 1);

      // Frame one line short.
      gen_frame(V_T - 1, -1, 0);
      check("short_still_locked", int'(locked), 1);
      gen_frame(V_T, -1, 0);
      check("short_frame_lines", int'(frame_lines), V_T - 1);
      check("short_unlocked", int'(locked), 0);
      check("short_err", int'(err_cnt), ERR_EN ? 1 : 0);

      // Randomly perturbed frames, then raw random sync/de activity.
      for (int f = 0; f < 30; f++) begin
         int lines, ll, ex;
         lines = V_T;
         if ($urandom_range(0, 5) == 0) lines = ($urandom_range(0, 1) == 1) ? V_T + 1 : V_T - 1;
         ll = -1; ex = 0;
         if ($urandom_range(0, 4) == 0) begin
            ll = int'($urandom_range(0, V_T - 2));
            ex = ($urandom_range(0, 1) == 1) ? 1 : -1;
         end
         gen_frame(lines, ll, ex);
      end
      repeat (400) cycle($urandom_range(0, 7) != 0, $urandom_range(0, 15) != 0, $urandom_range(0, 1) == 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
